timer_counter: RTL and testbench



---
 rtl/tc_pkg.sv | 23 ++
 rtl/timer_counter.sv | 143 ++++++++++++++
 tb/tb_timer_counter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the timer_counter register map, FSM state codes and CTRL fields.
// IDLE is encoded as 2'd1 so the status word reads 0x1B after a one-shot expiry.
package tc_pkg;
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_STAT   = 2'd3;

    typedef enum logic [1:0] {
        S_INT  = 2'd0,
        S_IDLE = 2'd1,
        S_LOAD = 2'd2,
        S_CNT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
endpackage

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with registered interrupt output.
// Optional status word at offset 3 when TC_STATUS_REG_EN is defined.
module timer_counter
    import tc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout,
    output logic              IRQ
);

    localparam logic [DATA_W-1:0] CNT_ONE = DATA_W'(1);

    logic [3:0]        ctrl;
    logic [DATA_W-1:0] preset;
    logic [DATA_W-1:0] count;
    logic              pend;
    tc_state_e         state;
    tc_state_e         state_nxt;

    logic [1:0] off;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       stat_clr;
    logic       en;
    logic       reload;
    logic       unused_addr;

    logic do_load;
    logic do_dec;
    logic do_expire;
    logic do_clr_en;
    logic do_clr_pend;

    assign off         = Addr[3:2];
    assign unused_addr = ^{Addr[ADDR_W-1:4], Addr[1:0]};
    assign wr_ctrl     = WE && (off == TC_CTRL);
    assign wr_preset   = WE && (off == TC_PRESET);
    assign en          = ctrl[CTRL_EN];
    assign reload      = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

`ifdef TC_STATUS_REG_EN
    assign stat_clr = WE && (off == TC_STAT) && Din[0];
`else
    assign stat_clr = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_CNT;
            S_CNT: begin
                if (!en)                 state_nxt = S_IDLE;
                else if (count <= CNT_ONE) state_nxt = S_INT;
            end
            S_INT:   state_nxt = reload ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A count of 0 or 1 expires on the next CNT cycle, so PRESET=0 acts like PRESET=1.
    always_comb begin
        do_load     = 1'b0;
        do_dec      = 1'b0;
        do_expire   = 1'b0;
        do_clr_en   = 1'b0;
        do_clr_pend = 1'b0;
        case (state)
            S_LOAD: do_load = 1'b1;
            S_CNT: begin
                if (en) begin
                    if (count > CNT_ONE) do_dec    = 1'b1;
                    else                 do_expire = 1'b1;
                end
            end
            S_INT: begin
                if (reload) do_clr_pend = 1'b1;
                else        do_clr_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // A CPU write to CTRL overrides the one-shot EN clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          ctrl <= '0;
        else if (wr_ctrl)   ctrl <= Din[3:0];
        else if (do_clr_en) ctrl[CTRL_EN] <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          preset <= '0;
        else if (wr_preset) preset <= Din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          count <= '0;
        else if (do_load)   count <= preset;
        else if (do_dec)    count <= count - CNT_ONE;
        else if (do_expire) count <= '0;
    end

    // Status clear beats a same-cycle expiry; an expiry beats a CTRL-write clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        pend <= 1'b0;
        else if (stat_clr)                pend <= 1'b0;
        else if (do_expire)               pend <= 1'b1;
        else if (wr_ctrl || do_clr_pend)  pend <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) IRQ <= 1'b0;
        else       IRQ <= pend & ctrl[CTRL_IM];
    end

    always_comb begin
        Dout = '0;
        case (off)
            TC_CTRL:   Dout[3:0] = ctrl;
            TC_PRESET: Dout = preset;
            TC_COUNT:  Dout = count;
`ifdef TC_STATUS_REG_EN
            TC_STAT:   Dout[4:0] = {IRQ, pend, state, 1'b1};
`else
            TC_STAT:   Dout = '0;
`endif
            default:   Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed scenarios plus randomized register traffic checked against a reference model.
module tb_timer_counter;
    import tc_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef TC_STATUS_REG_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] Addr;
    logic              WE;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;
    logic              IRQ;

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;
    logic        m_irq;
    int          m_phase;

    timer_counter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input logic [1:0] off);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = off;
        Addr = a;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        WE = 1'b0;
        set_addr(off);
        #1;
        d = Dout;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        @(negedge clk);
        set_addr(off);
        Din = d;
        WE  = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        WE = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_preset = '0; m_count = '0;
        m_pend = 1'b0; m_irq = 1'b0; m_phase = PH_IDLE;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {28'b0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [1:0] off, input logic [31:0] din);
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset, n_count;
        logic        n_pend, expired;
        int          n_phase;
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
        n_pend = m_pend; n_phase = m_phase; expired = 1'b0;
        case (m_phase)
            PH_IDLE: if (m_ctrl[0]) n_phase = PH_LOAD;
            PH_LOAD: begin n_count = m_preset; n_phase = PH_CNT; end
            PH_CNT: begin
                if (!m_ctrl[0]) n_phase = PH_IDLE;
                else if (m_count > 1) n_count = m_count - 1;
                else begin n_count = 0; n_pend = 1'b1; expired = 1'b1; n_phase = PH_INT; end
            end
            default: begin
                if (m_ctrl[2:1] == 2'd1) begin n_pend = 1'b0; n_phase = PH_LOAD; end
                else begin n_ctrl[0] = 1'b0; n_phase = PH_IDLE; end
            end
        endcase
        if (we && off == 2'd0) begin
            n_ctrl = din[3:0];
            if (!expired) n_pend = 1'b0;
        end
        if (we && off == 2'd1) n_preset = din;
        if (STAT_EN && we && off == 2'd3 && din[0]) n_pend = 1'b0;
        m_irq = m_pend & m_ctrl[3];
        m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
        m_pend = n_pend; m_phase = n_phase;
    endtask

    initial begin
        logic [31:0] d;
        logic        we;
        logic [1:0]  off;
        logic [1:0]  roff;
        logic [31:0] din;

        reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
        apply_reset();

        // Reset values
        rd(TC_CTRL, d);   chk("rst_ctrl", d, 32'h0);
        rd(TC_PRESET, d); chk("rst_preset", d, 32'h0);
        rd(TC_COUNT, d);  chk("rst_count", d, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);

        // Asynchronous reset in the middle of a count
        wr(TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'h1);
        tick(7);
        rd(TC_COUNT, d); chk("midrst_pre_count", d, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        rd(TC_COUNT, d); chk("midrst_count", d, 32'h0);
        rd(TC_CTRL, d);  chk("midrst_ctrl", d, 32'h0);
        chk("midrst_irq", 32'(IRQ), 32'h0);
        reset = 1'b0;
        tick(3);
        rd(TC_COUNT, d); chk("midrst_idle_count", d, 32'h0);
        if (STAT_EN) begin
            rd(TC_STAT, d); chk("midrst_stat", d, 32'h3);
        end

        // One-shot from PRESET=5 with interrupt enabled
        apply_reset();
        wr(TC_PRESET, 32'd5);
        wr(TC_CTRL, 32'h9);
        tick(2);
        rd(TC_COUNT, d); chk("os_count_load", d, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            rd(TC_COUNT, d); chk("os_count", d, 32'(5 - k));
        end
        chk("os_irq_lag", 32'(IRQ), 32'h0);
        tick(1);
        chk("os_irq_rise", 32'(IRQ), 32'h1);
        rd(TC_CTRL, d);  chk("os_en_cleared", d, 32'h8);
        rd(TC_COUNT, d); chk("os_count_zero", d, 32'h0);
        tick(4);
        chk("os_irq_held", 32'(IRQ), 32'h1);
        wr(TC_CTRL, 32'h0);
        chk("os_irq_reg_lag", 32'(IRQ), 32'h1);
        tick(1);
        chk("os_irq_cleared", 32'(IRQ), 32'h0);

        // Auto-reload, PRESET=3: one-cycle pulses every 5 cycles
        apply_reset();
        wr(TC_PRESET, 32'd3);
        wr(TC_CTRL, 32'hB);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            chk("ar_irq", 32'(IRQ), 32'(i == 6 || i == 11 || i == 16));
        end
        rd(TC_CTRL, d); chk("ar_en_kept", d, 32'hB);

        // PRESET=0 acts as 1, never wraps
        apply_reset();
        wr(TC_PRESET, 32'd0);
        wr(TC_CTRL, 32'h9);
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            rd(TC_COUNT, d); chk("p0_count", d, 32'h0);
            chk("p0_irq", 32'(IRQ), 32'(i >= 4));
        end
        wr(TC_CTRL, 32'h0);

        // PRESET rewritten mid-count only affects the next period
        apply_reset();
        wr(TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'hB);
        tick(4);
        rd(TC_COUNT, d); chk("mp_count8", d, 32'd8);
        wr(TC_PRESET, 32'd100);
        rd(TC_COUNT, d); chk("mp_count7", d, 32'd7);
        tick(7);
        rd(TC_COUNT, d); chk("mp_expire", d, 32'h0);
        chk("mp_irq_lag", 32'(IRQ), 32'h0);
        tick(1);
        chk("mp_irq", 32'(IRQ), 32'h1);
        tick(1);
        rd(TC_COUNT, d); chk("mp_reload", d, 32'd100);
        tick(1);
        rd(TC_COUNT, d); chk("mp_dec", d, 32'd99);

        // Status word at offset 3
        apply_reset();
        wr(TC_PRESET, 32'd2);
        wr(TC_CTRL, 32'h9);
        tick(5);
        chk("st_irq", 32'(IRQ), 32'h1);
`ifdef TC_STATUS_REG_EN
        rd(TC_STAT, d); chk("st_word", d, 32'h0000_001B);
        wr(TC_STAT, 32'h1);
        chk("st_irq_lag", 32'(IRQ), 32'h1);
        tick(1);
        chk("st_irq_clr", 32'(IRQ), 32'h0);
        rd(TC_STAT, d); chk("st_word_clr", d, 32'h3);
        rd(TC_CTRL, d); chk("st_ctrl_kept", d, 32'h8);
`else
        rd(TC_STAT, d); chk("st_reads0", d, 32'h0);
        wr(TC_STAT, 32'hFFFF_FFFF);
        tick(1);
        chk("st_irq_kept", 32'(IRQ), 32'h1);
        rd(TC_STAT, d); chk("st_still0", d, 32'h0);
`endif

        // Random register traffic against the reference model
        apply_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            we  = (($urandom % 4) == 0);
            off = 2'($urandom % 4);
            din = $urandom;
            if (off == 2'd0 && ($urandom % 4) != 0) din[0] = 1'b1;
            if (off == 2'd1) din = $urandom % 6;
            set_addr(off);
            Din = din;
            WE  = we;
            @(posedge clk);
            model_step(we, off, din);
            #1;
            WE = 1'b0;
            roff = 2'($urandom % 4);
            rd(roff, d);
            chk("rnd_irq", 32'(IRQ), 32'(m_irq));
            if (!(STAT_EN && roff == 2'd3)) chk("rnd_dout", d, model_read(roff));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
